// File: rtl/sys_defs_pkg.sv
// Shared system definitions: superscalar width and the fetch-to-dispatch packet.
// SUPERSCALAR_WAYS defaults to 3 unless the build overrides it.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package sys_defs;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } FETCH_DISPATCH_PACKET;

endpackage

// File: rtl/fetch_buffer_select.sv
// Head-relative W-way read mux over the circular buffer storage.
// Lanes at or beyond the current occupancy are forced invalid.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module fetch_buffer_select
    import sys_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = `SUPERSCALAR_WAYS
) (
    input  FETCH_DISPATCH_PACKET                 entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]             head_idx,
    input  logic [$clog2(DEPTH+1)-1:0]           count,
    output FETCH_DISPATCH_PACKET [W-1:0]         lanes
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] rd_idx [W];

    // Index arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            rd_idx[i]      = head_idx + IDX_W'(i);
            lanes[i]       = entries[rd_idx[i]];
            lanes[i].valid = entries[rd_idx[i]].valid && (int'(count) > i);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between fetch and dispatch, W lanes in and out.
// Optional same-cycle fetch-to-dispatch bypass: define FETCH_BUFFER_BYPASS_EN.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module fetch_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = `SUPERSCALAR_WAYS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          branch_flush_en,
    input  FETCH_DISPATCH_PACKET [W-1:0]  fetch_in,
    input  logic [$clog2(W+1)-1:0]        dispatch_take_in,
    output FETCH_DISPATCH_PACKET [W-1:0]  buffer_out,
    output logic                          buffer_ready_out,
    output logic [$clog2(DEPTH+1)-1:0]    buffer_count_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [CNT_W-1:0]             count;
    FETCH_DISPATCH_PACKET         mem [DEPTH];
    FETCH_DISPATCH_PACKET [W-1:0] stored_lanes;
    FETCH_DISPATCH_PACKET [W-1:0] push_lanes;
    logic [IDX_W-1:0]             wr_idx [W];
    logic                         bypass_ok;
    int                           fetch_valid_cnt;
    int                           push_cnt;
    int                           out_valid_cnt;
    int                           pop_cnt;
    int                           pop_stored;
    int                           bypass_used;
    int                           store_cnt;

    fetch_buffer_select #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_select (
        .entries  (mem),
        .head_idx (head[IDX_W-1:0]),
        .count    (count),
        .lanes    (stored_lanes)
    );

    assign buffer_ready_out = (DEPTH - int'(count)) >= W;
    assign buffer_count_out = count;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_ok = buffer_ready_out && !branch_flush_en && !reset;
`else
    assign bypass_ok = 1'b0;
`endif

    // Empty output lanes may be filled straight from fetch when bypass is built in.
    always_comb begin
        buffer_out = stored_lanes;
        if (bypass_ok) begin
            for (int i = 0; i < W; i++) begin
                for (int k = 0; k < W; k++) begin
                    if (i >= int'(count) && k == i - int'(count)) begin
                        buffer_out[i] = fetch_in[k];
                    end
                end
            end
        end
    end

    always_comb begin
        fetch_valid_cnt = 0;
        out_valid_cnt   = 0;
        for (int i = 0; i < W; i++) begin
            if (fetch_in[i].valid) fetch_valid_cnt = fetch_valid_cnt + 1;
            if (buffer_out[i].valid) out_valid_cnt = out_valid_cnt + 1;
        end
        push_cnt    = buffer_ready_out ? fetch_valid_cnt : 0;
        pop_cnt     = (int'(dispatch_take_in) < out_valid_cnt) ? int'(dispatch_take_in) : out_valid_cnt;
        pop_stored  = (pop_cnt < int'(count)) ? pop_cnt : int'(count);
        bypass_used = pop_cnt - pop_stored;
        store_cnt   = push_cnt - bypass_used;
    end

    // Bypassed lanes that dispatch consumed are skipped; the rest are enqueued in order.
    always_comb begin
        for (int j = 0; j < W; j++) begin
            push_lanes[j] = '0;
            wr_idx[j]     = tail[IDX_W-1:0] + IDX_W'(j);
            for (int k = 0; k < W; k++) begin
                if (k == j + bypass_used) push_lanes[j] = fetch_in[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (branch_flush_en) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int j = 0; j < W; j++) begin
                if (j < store_cnt) mem[wr_idx[j]] <= push_lanes[j];
            end
            head  <= head + PTR_W'(pop_stored);
            tail  <= tail + PTR_W'(store_cnt);
            count <= CNT_W'(int'(count) + push_cnt - pop_cnt);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (W=3, DEPTH=16).
// Covers both the default build and the FETCH_BUFFER_BYPASS_EN build.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module tb_fetch_buffer;
    import sys_defs::*;

    localparam int W      = `SUPERSCALAR_WAYS;
    localparam int DEPTH  = 16;
    localparam int TAKE_W = $clog2(W+1);
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         branch_flush_en;
    FETCH_DISPATCH_PACKET [W-1:0] fetch_in;
    logic [TAKE_W-1:0]            dispatch_take_in;
    FETCH_DISPATCH_PACKET [W-1:0] buffer_out;
    logic                         buffer_ready_out;
    logic [CNT_W-1:0]             buffer_count_out;

    int          compare_count  = 0;
    int          mismatch_count = 0;
    int          cur_n;
    int          cur_take;
    logic [31:0] cur_pc;
    logic [31:0] pc;
    logic [31:0] model_q [$];

    fetch_buffer #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .branch_flush_en  (branch_flush_en),
        .fetch_in         (fetch_in),
        .dispatch_take_in (dispatch_take_in),
        .buffer_out       (buffer_out),
        .buffer_ready_out (buffer_ready_out),
        .buffer_count_out (buffer_count_out)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(input int n, input logic [31:0] pc_base, input int take, input logic flush);
        for (int i = 0; i < W; i++) begin
            fetch_in[i].valid = (i < n);
            fetch_in[i].pc    = pc_base + 32'(4*i);
            fetch_in[i].inst  = ~(pc_base + 32'(4*i));
        end
        dispatch_take_in = TAKE_W'(take);
        branch_flush_en  = flush;
        cur_n    = n;
        cur_pc   = pc_base;
        cur_take = take;
    endtask

    // Reference queue of PCs: pop what dispatch can see, push what fetch may push.
    task automatic tick();
        int sz;
        int vis;
        int t;
        bit rdy;
        sz  = model_q.size();
        rdy = (DEPTH - sz) >= W;
        if (branch_flush_en) begin
            model_q.delete();
        end else begin
            if (rdy) begin
                for (int i = 0; i < cur_n; i++) model_q.push_back(cur_pc + 32'(4*i));
            end
`ifdef FETCH_BUFFER_BYPASS_EN
            vis = (model_q.size() < W) ? model_q.size() : W;
`else
            vis = (sz < W) ? sz : W;
`endif
            t = (cur_take < vis) ? cur_take : vis;
            repeat (t) void'(model_q.pop_front());
        end
        @(posedge clock);
        #1;
        driveInputs(0, 32'h0, 0, 1'b0);
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] pc_base, input int take, input logic flush);
        driveInputs(n, pc_base, take, flush);
        tick();
    endtask

    task automatic checkState(input string tag);
        bit exp_valid;
        checkOutput({tag, "_count"}, 64'(buffer_count_out), 64'(model_q.size()));
        checkOutput({tag, "_ready"}, 64'(buffer_ready_out), 64'((DEPTH - model_q.size()) >= W));
        for (int i = 0; i < W; i++) begin
            exp_valid = (i < model_q.size());
            checkOutput({tag, "_valid"}, 64'(buffer_out[i].valid), 64'(exp_valid));
            if (exp_valid) checkOutput({tag, "_pc"}, 64'(buffer_out[i].pc), 64'(model_q[i]));
        end
    endtask

    initial begin
        driveInputs(0, 32'h0, 0, 1'b0);
        #12;
        checkOutput("rst_count", 64'(buffer_count_out), 64'd0);
        checkOutput("rst_ready", 64'(buffer_ready_out), 64'd1);
        checkOutput("rst_valid0", 64'(buffer_out[0].valid), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int k = 0; k < 5; k++) begin
            applyStimulus(3, 32'h100 + 32'(12*k), 0, 1'b0);
            checkOutput("fill_count", 64'(buffer_count_out), 64'(3*(k+1)));
        end
        checkOutput("full_ready", 64'(buffer_ready_out), 64'd0);
        applyStimulus(3, 32'h200, 0, 1'b0);
        checkOutput("drop_count", 64'(buffer_count_out), 64'd15);
        checkOutput("full_pc0", 64'(buffer_out[0].pc), 64'h100);
        checkOutput("full_pc2", 64'(buffer_out[2].pc), 64'h108);

        for (int k = 0; k < 3; k++) applyStimulus(0, 32'h0, 3, 1'b0);
        checkOutput("drain_count", 64'(buffer_count_out), 64'd6);
        checkOutput("drain_pc0", 64'(buffer_out[0].pc), 64'h124);

        // Twenty push-3/take-3 cycles carry the pointers across the 15->0 wrap.
        pc = 32'h13C;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(3, pc, 3, 1'b0);
            pc = pc + 32'd12;
            checkOutput("steady_count", 64'(buffer_count_out), 64'd6);
            checkState("steady");
        end

        applyStimulus(0, 32'h0, 3, 1'b0);
        applyStimulus(0, 32'h0, 1, 1'b0);
        checkOutput("ovt_pre_count", 64'(buffer_count_out), 64'd2);
        applyStimulus(0, 32'h0, 3, 1'b0);
        checkOutput("ovt_count", 64'(buffer_count_out), 64'd0);
        checkOutput("ovt_valid0", 64'(buffer_out[0].valid), 64'd0);
        checkOutput("ovt_valid1", 64'(buffer_out[1].valid), 64'd0);
        checkOutput("ovt_ready", 64'(buffer_ready_out), 64'd1);

        for (int k = 0; k < 3; k++) applyStimulus(3, 32'h300 + 32'(12*k), 0, 1'b0);
        checkOutput("preflush_count", 64'(buffer_count_out), 64'd9);
        applyStimulus(3, 32'h400, 2, 1'b1);
        checkOutput("flush_count", 64'(buffer_count_out), 64'd0);
        checkOutput("flush_valid0", 64'(buffer_out[0].valid), 64'd0);
        checkOutput("flush_valid2", 64'(buffer_out[2].valid), 64'd0);
        checkOutput("flush_ready", 64'(buffer_ready_out), 64'd1);

`ifdef FETCH_BUFFER_BYPASS_EN
        driveInputs(3, 32'h500, 2, 1'b0);
        #1;
        checkOutput("byp_valid0", 64'(buffer_out[0].valid), 64'd1);
        checkOutput("byp_pc0", 64'(buffer_out[0].pc), 64'h500);
        checkOutput("byp_pc1", 64'(buffer_out[1].pc), 64'h504);
        tick();
        checkOutput("byp_count", 64'(buffer_count_out), 64'd1);
        checkOutput("byp_next_pc0", 64'(buffer_out[0].pc), 64'h508);
`else
        driveInputs(1, 32'h500, 0, 1'b0);
        #1;
        checkOutput("lat_comb_valid0", 64'(buffer_out[0].valid), 64'd0);
        tick();
        checkOutput("lat_count", 64'(buffer_count_out), 64'd1);
        checkOutput("lat_pc0", 64'(buffer_out[0].pc), 64'h500);
`endif
        applyStimulus(0, 32'h0, 1, 1'b0);
        checkState("empty");

        applyStimulus(3, 32'h600, 0, 1'b0);
        applyStimulus(3, 32'h60C, 0, 1'b0);
        applyStimulus(1, 32'h618, 0, 1'b0);
        checkOutput("prerst_count", 64'(buffer_count_out), 64'd7);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("arst_count", 64'(buffer_count_out), 64'd0);
        checkOutput("arst_ready", 64'(buffer_ready_out), 64'd1);
        checkOutput("arst_valid0", 64'(buffer_out[0].valid), 64'd0);
        model_q.delete();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        applyStimulus(1, 32'h900, 0, 1'b0);
        checkOutput("postrst_count", 64'(buffer_count_out), 64'd1);
        checkOutput("postrst_pc0", 64'(buffer_out[0].pc), 64'h900);
        checkOutput("postrst_valid1", 64'(buffer_out[1].valid), 64'd0);
        checkState("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
